// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, frame-format defaults,
// baud divisor width and a small constant helper.
package uart_pkg;

  // Frame-format defaults, shared by the receiver and the transmitter.
  localparam int unsigned DBIT_DEF    = 8;   // data bits per frame
  localparam int unsigned SB_TICK_DEF = 16;  // stop-bit length in oversample ticks

  // Baud divisor width; the tick period is dvsr+1 clk cycles.
  localparam int unsigned DVSR_W = 11;

  // Oversampling factor: oversample ticks per bit.
  localparam int unsigned OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    st_idle,
    st_start,
    st_data,
    st_stop
  } state_type;

  // Larger of two unsigned values; used to size counters at elaboration time.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/baud_gen.sv
// Free-running oversample tick generator. The counter runs 0..limit and wraps.
// tick is high for the one cycle in which the counter sits at its limit.
// The limit is reloaded from dvsr only at a wrap. A divisor change therefore
// takes effect cleanly at the next wrap. It also means a smaller divisor can
// never leave the counter stranded above its terminal value.
module baud_gen
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              tick
);

  logic [DVSR_W-1:0] cnt_q, cnt_d;
  logic [DVSR_W-1:0] lim_q, lim_d;
  logic              wrap;

  // Counter and active-limit registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end

  // Wrap detection, next count and limit reload.
  always_comb begin
    wrap  = (cnt_q == lim_q);
    cnt_d = wrap ? '0 : cnt_q + DVSR_W'(1);
    lim_d = wrap ? dvsr : lim_q;
    tick  = wrap;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling.
// rx is synchronised first. A falling level starts a frame. The start bit is
// confirmed at its midpoint, and every following bit is sampled 16 ticks later.
// A completed frame loads dout and raises rx_done_tick for one cycle.
// frame_err is raised alongside it when the stop bit was sampled low.
// After a low stop bit the line must be seen high again before a new start is
// accepted. This keeps a held-low line (break) from producing an endless
// stream of frames.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = DBIT_DEF,
  parameter int unsigned SB_TICK = SB_TICK_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic [DVSR_W-1:0] dvsr,
  output logic [DBIT-1:0]   dout,
  output logic              rx_done_tick,
  output logic              frame_err
);

  // s must hold 15 (data-bit length) as well as SB_TICK-1.
  localparam int unsigned SW = max_u(4, $clog2(SB_TICK));
  localparam int unsigned NW = max_u(1, $clog2(DBIT));

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic            tick;
  logic [1:0]      sync_q;
  logic            rx_s;

  state_type       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            need_high_q, need_high_d;

  baud_gen u_baud (
    .clk  (clk),
    .rst  (rst),
    .dvsr (dvsr),
    .tick (tick)
  );

  // Two-flop synchroniser. It resets to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  // State register: FSM state, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= st_idle;
      s_q         <= '0;
      n_q         <= '0;
      b_q         <= '0;
      dout_q      <= '0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
      need_high_q <= 1'b1;  // only a fresh low after reset may start a frame
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      b_q         <= b_d;
      dout_q      <= dout_d;
      done_q      <= done_d;
      ferr_q      <= ferr_d;
      need_high_q <= need_high_d;
    end
  end

  // Next-state logic: FSM transitions, tick/bit counters and the shift register.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    b_d         = b_q;
    need_high_d = need_high_q & ~rx_s;

    unique case (state_q)
      st_idle: begin
        if (!rx_s && !need_high_q) begin
          state_d = st_start;
          s_d     = '0;
          n_d     = '0;
        end
      end

      st_start: begin
        if (tick) begin
          if (s_q == S_MID) begin
            // A high level at mid start bit is a glitch: go back to idle.
            state_d = rx_s ? st_idle : st_data;
            s_d     = '0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      st_data: begin
        if (tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = st_stop;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      st_stop: begin
        if (tick) begin
          if (s_q == S_STOP) begin
            state_d = st_idle;
            s_d     = '0;
            // A low stop bit may be a break; require the line to go high first.
            if (!rx_s) begin
              need_high_d = 1'b1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      default: begin
        state_d = st_idle;
        s_d     = '0;
        n_d     = '0;
      end
    endcase
  end

  // Output logic: frame completion, error flag and the held data word.
  always_comb begin
    done_d = (state_q == st_stop) && tick && (s_q == S_STOP);
    ferr_d = done_d && !rx_s;
    dout_d = done_d ? b_q : dout_q;
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;

endmodule
